dual_input_debouncer: RTL and testbench

Two-channel synchronizer and debouncer that conditions raw, asynchronous switch or pin inputs into clean single-bit logic signals. Each channel also produces one-cycle rise and fall pulses. It sits directly upstream of the combinational gate stages: `a_clean` and `b_clean` drive the `a` and `b` inputs of the gate logic. Each channel is independent; the two share only clock and reset.

---
 rtl/dual_input_debouncer.sv | 92 +++++++++
 tb/tb_dual_input_debouncer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : dual_input_debouncer
// Brief    : Two independent channels. Each channel has a 2-flop synchronizer,
//            a stability counter, a registered clean level and one-cycle
//            rise/fall pulses.
// Revision : 1.0  initial release
// ============================================================================
module dual_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    // Terminal count. The clean level follows the synchronized input on the
    // edge where the counter already holds this value and a mismatch persists.
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is channel A and bit 1 is channel B.
    logic [1:0] w_raw;
    logic [1:0] w_clean;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {raw_b, raw_a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             r_s1;
            logic             r_s2;
            logic             r_clean;
            logic             r_rise;
            logic             r_fall;
            logic [CNT_W-1:0] r_cnt;

            // Synchronize, count consecutive mismatches, and update the clean level with its pulse.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_clean <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1   <= w_raw[gi];
                    r_s2   <= r_s1;
                    // Pulses last only for the edge that changes the level.
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (r_s2 != r_clean) begin
                        if (r_cnt == c_limit) begin
                            r_clean <= r_s2;
                            r_cnt   <= '0;
                            r_rise  <= r_s2;
                            r_fall  <= ~r_s2;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        // The input returned to the clean level, so a partial count is a glitch.
                        r_cnt <= '0;
                    end
                end
            end

            assign w_clean[gi] = r_clean;
            assign w_rise[gi]  = r_rise;
            assign w_fall[gi]  = r_fall;
        end
    endgenerate

    assign a_clean = w_clean[0];
    assign b_clean = w_clean[1];
    assign a_rise  = w_rise[0];
    assign b_rise  = w_rise[1];
    assign a_fall  = w_fall[0];
    assign b_fall  = w_fall[1];

endmodule
`default_nettype wire

// File: tb/tb_dual_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_input_debouncer
// Brief    : Self-checking bench for dual_input_debouncer (DEBOUNCE_CYCLES=4,
//            CNT_W=4). A history-window reference model supplies the expected
//            outputs. Directed scenarios are followed by randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_dual_input_debouncer;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_a = 1'b0;
    logic raw_b = 1'b0;
    logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;

    int n_checks = 0;
    int n_pass   = 0;

    dual_input_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall)
    );

    always #5 clk = ~clk;

    // Reference model. hist holds the raw {b,a} value sampled on each edge
    // since reset, and reset fills it with zeros. The clean level of a channel
    // flips when the synchronized input seen on the last D edges (the raw value
    // two edges earlier) differs from the current clean level on every one of
    // those edges.
    logic [1:0] hist[$];
    logic [1:0] m_clean, m_rise, m_fall;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(2'b00);
        m_clean = 2'b00;
        m_rise  = 2'b00;
        m_fall  = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] raw);
        int L;
        L = hist.size();
        for (int ch = 0; ch < 2; ch++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (hist[L-1-k][ch] == m_clean[ch]) all_diff = 1'b0;
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (all_diff) begin
                m_clean[ch] = ~m_clean[ch];
                m_rise[ch]  = m_clean[ch];
                m_fall[ch]  = ~m_clean[ch];
            end
        end
        hist.push_back(raw);
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int outs();
        return {a_clean, a_rise, a_fall, b_clean, b_rise, b_fall};
    endfunction

    function automatic int model_outs();
        return {m_clean[0], m_rise[0], m_fall[0], m_clean[1], m_rise[1], m_fall[1]};
    endfunction

    // Called at negedge+2. Drives the inputs, advances the model on the edge,
    // and checks the outputs on the following negedge.
    task automatic tick(input logic a, input logic b);
        raw_a = a;
        raw_b = b;
        @(posedge clk);
        model_edge({b, a});
        @(negedge clk);
        chk("outs", outs(), model_outs());
        #2;
    endtask

    // Asserts reset in mid-cycle, checks that the outputs clear immediately,
    // and holds reset across one edge.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        model_reset();
        #1 chk("rst_async", outs(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", outs(), 0);
        #2 rst = 1'b0;
    endtask

    int lat, lat_b, rises, rem_a, rem_b;
    logic va, vb;

    initial begin
        model_reset();
        @(negedge clk);
        #2;

        // Reset release with both raw inputs high. Both clean levels should rise at edge 5.
        raw_a = 1'b1;
        raw_b = 1'b1;
        chk("rst_val", outs(), 0);
        rst = 1'b0;
        lat = -1;
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            if (a_rise && b_rise) rises++;
            if (a_clean && b_clean && lat < 0) lat = i;
        end
        chk("rel_latency", lat, 5);
        chk("rel_rise_cnt", rises, 1);

        // An asynchronous reset with the outputs high must clear them at once.
        pulse_reset();
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

        // Clean step: the rise and the fall each appear 5 edges after the new value is first sampled.
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            if (a_rise && lat < 0) lat = i;
        end
        chk("step_rise", lat, 5);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            if (a_fall && lat < 0) lat = i;
        end
        chk("step_fall", lat, 5);

        // Glitch rejection: a 3-cycle high is filtered out and a 4-cycle high is accepted.
        rises = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            rises += int'(a_rise);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            rises += int'(a_rise);
        end
        chk("glitch3", rises, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            rises += int'(a_rise);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            rises += int'(a_rise);
        end
        chk("glitch4", rises, 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

        // Bounce train 1,0,1,1,0,1 then hold 1. The single rise is 5 edges after index 5.
        begin
            logic [5:0] bounce;
            bounce = 6'b101101;
            rises = 0;
            lat = -1;
            for (int i = 0; i < 20; i++) begin
                tick((i < 6) ? bounce[5-i] : 1'b1, 1'b0);
                if (a_rise) begin
                    rises++;
                    if (lat < 0) lat = i;
                end
            end
            chk("bounce_cnt", rises, 1);
            chk("bounce_lat", lat, 10);
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

        // Simultaneous channels: both rises fall on the same edge.
        lat = -1;
        lat_b = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            if (a_rise && lat < 0) lat = i;
            if (b_rise && lat_b < 0) lat_b = i;
        end
        chk("simul_a", lat, 5);
        chk("simul_b", lat_b, 5);

        // Reset mid-count discards the partial count, so the full latency applies after release.
        pulse_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        pulse_reset();
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            if (a_clean && lat < 0) lat = i;
        end
        chk("midcnt_lat", lat, 5);

        // Randomized hold lengths per channel, with occasional asynchronous resets.
        va = 1'b0;
        vb = 1'b0;
        rem_a = 0;
        rem_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_a == 0) begin
                va = 1'($urandom_range(0, 1));
                rem_a = $urandom_range(1, 8);
            end
            if (rem_b == 0) begin
                vb = 1'($urandom_range(0, 1));
                rem_b = $urandom_range(1, 8);
            end
            rem_a--;
            rem_b--;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            tick(va, vb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
